// File: rtl/otter_csr_pkg.sv
// Shared CSR addresses, bit positions and the mstatus layout for the OTTER CSR file.
package otter_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIE_MEIE_BIT     = 11;
    localparam int MIP_MEIP_BIT     = 11;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

    typedef struct packed {
        logic [23:0] rsv_hi;
        logic        mpie;
        logic [2:0]  rsv_mid;
        logic        mie;
        logic [2:0]  rsv_lo;
    } mstatus_t;

    function automatic logic [31:0] pack_mstatus(input logic mie, input logic mpie);
        mstatus_t s;
        s      = 32'h0000_0000;
        s.mie  = mie;
        s.mpie = mpie;
        return s;
    endfunction

endpackage

// File: rtl/otter_intr_sync.sv
// External interrupt synchroniser, rising-edge detector and sticky pending flag.
module otter_intr_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic INTR,
    input  logic clr,
    output logic pending
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   pending_q, pending_d;
    logic                   rise_s;

    // Next-state: shift the synchroniser, detect a new edge, set beats clear
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], INTR};
        prev_d    = sync_q[SYNC_STAGES-1];
        rise_s    = sync_q[SYNC_STAGES-1] & ~prev_q;
        pending_d = rise_s | (pending_q & ~clr);
    end

    // State register with synchronous flush
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q    <= {SYNC_STAGES{1'b0}};
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/otter_csr.sv
// Machine-mode CSR file and interrupt entry for the OTTER MCU.
// Optional 64-bit mcycle counter enabled by defining OTTER_CSR_MCYCLE_EN.
module otter_csr
    import otter_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INTR,
    input  logic        CSR_WE,
    input  logic        INT_TAKEN,
    input  logic        MRET_EXEC,
    input  logic [11:0] ADDR,
    input  logic [31:0] WD,
    input  logic [31:0] PC,
    output logic [31:0] RD,
    output logic [31:0] MTVEC,
    output logic [31:0] MEPC,
    output logic        INTR_REQ
);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_meie_q, mie_meie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic        pending_s;
    logic [31:0] rd_s;
`ifdef OTTER_CSR_MCYCLE_EN
    logic [63:0] mcycle_q, mcycle_d;
`endif

    otter_intr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_intr_sync (
        .CLK     (CLK),
        .RST     (RST),
        .INTR    (INTR),
        .clr     (INT_TAKEN),
        .pending (pending_s)
    );

    // Next-state: trap entry beats mret beats a software write
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_meie_d     = mie_meie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
`ifdef OTTER_CSR_MCYCLE_EN
        mcycle_d       = mcycle_q + 64'd1;
`endif
        if (INT_TAKEN) begin
            mepc_d         = {PC[31:2], 2'b00};
            mcause_d       = MCAUSE_MEI;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (MRET_EXEC) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (CSR_WE) begin
            case (ADDR)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = WD[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = WD[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_meie_d = WD[MIE_MEIE_BIT];
                CSR_MTVEC:    mtvec_d    = {WD[31:2], 2'b00};
                CSR_MSCRATCH: mscratch_d = WD;
                CSR_MEPC:     mepc_d     = {WD[31:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = WD;
`ifdef OTTER_CSR_MCYCLE_EN
                CSR_MCYCLE:   mcycle_d   = {mcycle_q[63:32], WD};
                CSR_MCYCLEH:  mcycle_d   = {WD, mcycle_q[31:0]};
`endif
                default:      mcause_d   = mcause_q;
            endcase
        end else begin
            mcause_d = mcause_q;
        end
    end

    // CSR state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= {MTVEC_RST[31:2], 2'b00};
            mscratch_q     <= 32'h0000_0000;
            mepc_q         <= 32'h0000_0000;
            mcause_q       <= 32'h0000_0000;
`ifdef OTTER_CSR_MCYCLE_EN
            mcycle_q       <= 64'd0;
`endif
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_meie_q     <= mie_meie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
`ifdef OTTER_CSR_MCYCLE_EN
            mcycle_q       <= mcycle_d;
`endif
        end
    end

    // Read mux shows the value held before any write this cycle
    always_comb begin
        rd_s = 32'h0000_0000;
        case (ADDR)
            CSR_MSTATUS:  rd_s = pack_mstatus(mstatus_mie_q, mstatus_mpie_q);
            CSR_MIE:      rd_s[MIE_MEIE_BIT] = mie_meie_q;
            CSR_MTVEC:    rd_s = mtvec_q;
            CSR_MSCRATCH: rd_s = mscratch_q;
            CSR_MEPC:     rd_s = mepc_q;
            CSR_MCAUSE:   rd_s = mcause_q;
            CSR_MIP:      rd_s[MIP_MEIP_BIT] = pending_s;
`ifdef OTTER_CSR_MCYCLE_EN
            CSR_MCYCLE:   rd_s = mcycle_q[31:0];
            CSR_MCYCLEH:  rd_s = mcycle_q[63:32];
`endif
            default:      rd_s = 32'h0000_0000;
        endcase
    end

    assign RD       = rd_s;
    assign MTVEC    = mtvec_q;
    assign MEPC     = mepc_q;
    assign INTR_REQ = pending_s & mstatus_mie_q & mie_meie_q;

endmodule

// File: tb/tb_otter_csr.sv
// Self-checking bench for otter_csr: write/read table, interrupt sequences, random vs model.
module tb_otter_csr;

    localparam logic [31:0] MTVEC_RST_TB = 32'h0000_0100;
    localparam int          SYNC         = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        INTR = 1'b0;
    logic        CSR_WE = 1'b0;
    logic        INT_TAKEN = 1'b0;
    logic        MRET_EXEC = 1'b0;
    logic [11:0] ADDR = 12'h000;
    logic [31:0] WD = 32'h0;
    logic [31:0] PC = 32'h0;
    logic [31:0] RD, MTVEC, MEPC;
    logic        INTR_REQ;

    int n_checks = 0;
    int n_pass   = 0;

    otter_csr #(.MTVEC_RST(MTVEC_RST_TB), .SYNC_STAGES(SYNC)) dut (
        .CLK(CLK), .RST(RST), .INTR(INTR), .CSR_WE(CSR_WE), .INT_TAKEN(INT_TAKEN),
        .MRET_EXEC(MRET_EXEC), .ADDR(ADDR), .WD(WD), .PC(PC),
        .RD(RD), .MTVEC(MTVEC), .MEPC(MEPC), .INTR_REQ(INTR_REQ)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [31:0] m_csr [4096];
    logic        m_hist [SYNC+1];
    logic        m_pend;
    logic [63:0] m_cyc;

    function automatic logic [31:0] wmask(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_0088;
            12'h304: return 32'h0000_0800;
            12'h305: return 32'hFFFF_FFFC;
            12'h340: return 32'hFFFF_FFFF;
            12'h341: return 32'hFFFF_FFFC;
            12'h342: return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
`ifdef OTTER_CSR_MCYCLE_EN
        if (a == 12'hB00) return m_cyc[31:0];
        if (a == 12'hB80) return m_cyc[63:32];
`endif
        if (a == 12'h344) return m_pend ? 32'h0000_0800 : 32'h0;
        return m_csr[a];
    endfunction

    function automatic logic model_req();
        return m_pend & m_csr[12'h300][3] & m_csr[12'h304][11];
    endfunction

    task automatic model_edge();
        logic        rise;
        logic [63:0] cyc_next;
        if (RST) begin
            for (int i = 0; i < 4096; i++) m_csr[i] = 32'h0;
            m_csr[12'h305] = MTVEC_RST_TB;
            for (int i = 0; i <= SYNC; i++) m_hist[i] = 1'b0;
            m_pend = 1'b0;
            m_cyc  = 64'd0;
        end else begin
            rise = m_hist[SYNC-1] & ~m_hist[SYNC];
            for (int i = SYNC; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = INTR;
            m_pend    = rise | (m_pend & ~INT_TAKEN);
            cyc_next  = m_cyc + 64'd1;
            if (INT_TAKEN) begin
                m_csr[12'h341] = PC & 32'hFFFF_FFFC;
                m_csr[12'h342] = 32'h8000_000B;
                m_csr[12'h300] = m_csr[12'h300][3] ? 32'h80 : 32'h0;
            end else if (MRET_EXEC) begin
                m_csr[12'h300] = m_csr[12'h300][7] ? 32'h88 : 32'h80;
            end else if (CSR_WE) begin
                if (ADDR == 12'hB00) cyc_next = {m_cyc[63:32], WD};
                if (ADDR == 12'hB80) cyc_next = {WD, m_cyc[31:0]};
                m_csr[ADDR] = WD & wmask(ADDR);
            end
            m_cyc = cyc_next;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd_check(input string name, input logic [11:0] a, input logic [31:0] exp);
        ADDR = a;
        #1;
        check32(name, RD, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        CSR_WE = 1'b1; ADDR = a; WD = d;
        step();
        CSR_WE = 1'b0;
    endtask

    task automatic check_model(input string tag);
        #1;
        check32({tag, "_rd"}, RD, model_read(ADDR));
        check32({tag, "_mtvec"}, MTVEC, m_csr[12'h305]);
        check32({tag, "_mepc"}, MEPC, m_csr[12'h341]);
        check32({tag, "_req"}, {31'b0, INTR_REQ}, {31'b0, model_req()});
    endtask

    typedef struct {
        string       name;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [10];
    logic [11:0] addr_list [12];

    initial begin
        vecs[0] = '{"mtvec_mask",   12'h305, 32'h0000_0107, 12'h305, 32'h0000_0104};
        vecs[1] = '{"mip_ro",       12'h344, 32'hFFFF_FFFF, 12'h344, 32'h0000_0000};
        vecs[2] = '{"mstatus_mask", 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_0088};
        vecs[3] = '{"mie_mask",     12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0800};
        vecs[4] = '{"mscratch",     12'h340, 32'hDEAD_BEEF, 12'h340, 32'hDEAD_BEEF};
        vecs[5] = '{"mepc_mask",    12'h341, 32'h1234_5677, 12'h341, 32'h1234_5674};
        vecs[6] = '{"mcause",       12'h342, 32'hCAFE_F00D, 12'h342, 32'hCAFE_F00D};
        vecs[7] = '{"unimpl",       12'h123, 32'hFFFF_FFFF, 12'h123, 32'h0000_0000};
        vecs[8] = '{"mstatus_clr",  12'h300, 32'h0000_0000, 12'h300, 32'h0000_0000};
        vecs[9] = '{"mie_clr",      12'h304, 32'h0000_0000, 12'h304, 32'h0000_0000};
        addr_list = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                      12'h344, 12'hB00, 12'hB80, 12'h123, 12'h301, 12'hFFF};

        // reset
        RST = 1'b1; INTR = 1'b1;
        step();
        RST = 1'b0; INTR = 1'b0;
        rd_check("rst_mstatus", 12'h300, 32'h0);
        rd_check("rst_mtvec", 12'h305, MTVEC_RST_TB);
        check32("rst_mepc", MEPC, 32'h0);
        check32("rst_req", {31'b0, INTR_REQ}, 32'h0);

        // table of write/readback vectors
        for (int i = 0; i < 10; i++) begin
            wr(vecs[i].waddr, vecs[i].wdata);
            rd_check(vecs[i].name, vecs[i].raddr, vecs[i].exp_rd);
        end
        check32("mtvec_port", MTVEC, 32'h0000_0104);

        // read shows pre-write value during the write cycle
        RST = 1'b1; step(); RST = 1'b0;
        CSR_WE = 1'b1; ADDR = 12'h340; WD = 32'h0000_0055;
        #1; check32("prewrite_rd", RD, 32'h0);
        step(); CSR_WE = 1'b0; WD = 32'h0;
        rd_check("postwrite_rd", 12'h340, 32'h0000_0055);

        // interrupt entry with INTR held high
        RST = 1'b1; step(); RST = 1'b0;
        wr(12'h300, 32'h8);
        wr(12'h304, 32'h800);
        INTR = 1'b1;
        step(); check32("req_edge1", {31'b0, INTR_REQ}, 32'h0);
        step(); check32("req_edge2", {31'b0, INTR_REQ}, 32'h0);
        step(); check32("req_edge3", {31'b0, INTR_REQ}, 32'h1);
        rd_check("mip_pending", 12'h344, 32'h800);
        INT_TAKEN = 1'b1; PC = 32'h1C;
        step(); INT_TAKEN = 1'b0;
        check32("trap_mepc", MEPC, 32'h1C);
        rd_check("trap_mcause", 12'h342, 32'h8000_000B);
        rd_check("trap_mstatus", 12'h300, 32'h80);
        check32("trap_req", {31'b0, INTR_REQ}, 32'h0);
        MRET_EXEC = 1'b1; step(); MRET_EXEC = 1'b0;
        rd_check("mret_mstatus", 12'h300, 32'h88);
        for (int i = 0; i < 4; i++) step();
        check32("held_no_retrig", {31'b0, INTR_REQ}, 32'h0);

        // collisions: trap drops write, mret drops write
        INT_TAKEN = 1'b1; CSR_WE = 1'b1; ADDR = 12'h341; WD = 32'hFF; PC = 32'h200;
        step(); INT_TAKEN = 1'b0; CSR_WE = 1'b0;
        check32("coll_mepc", MEPC, 32'h200);
        rd_check("coll_mstatus", 12'h300, 32'h80);
        MRET_EXEC = 1'b1; CSR_WE = 1'b1; ADDR = 12'h340; WD = 32'h1;
        step(); MRET_EXEC = 1'b0; CSR_WE = 1'b0;
        rd_check("mret_drop_wr", 12'h340, 32'h0);
        rd_check("mret_mstatus2", 12'h300, 32'h88);

        // new edge in the same cycle as trap entry keeps pending set
        INTR = 1'b0; step(); step(); step();
        INTR = 1'b1; step(); step();
        INT_TAKEN = 1'b1; step(); INT_TAKEN = 1'b0;
        rd_check("set_wins_mip", 12'h344, 32'h800);
        check32("set_wins_req0", {31'b0, INTR_REQ}, 32'h0);
        MRET_EXEC = 1'b1; step(); MRET_EXEC = 1'b0;
        check32("set_wins_req1", {31'b0, INTR_REQ}, 32'h1);

        // mcycle carry across the halves
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'h0);
        step();
`ifdef OTTER_CSR_MCYCLE_EN
        rd_check("mcycleh_carry", 12'hB80, 32'h1);
        rd_check("mcycle_wrap", 12'hB00, 32'h0);
`else
        rd_check("mcycleh_absent", 12'hB80, 32'h0);
        rd_check("mcycle_absent", 12'hB00, 32'h0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            RST       = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) INTR = ~INTR;
            CSR_WE    = ($urandom_range(0, 2) == 0);
            INT_TAKEN = ($urandom_range(0, 11) == 0);
            MRET_EXEC = ($urandom_range(0, 11) == 0);
            ADDR      = addr_list[$urandom_range(0, 11)];
            WD        = $urandom;
            PC        = $urandom;
            step();
            ADDR = addr_list[$urandom_range(0, 11)];
            check_model("rand");
        end
        RST = 1'b0; CSR_WE = 1'b0; INT_TAKEN = 1'b0; MRET_EXEC = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
